// File: rtl/axis_sink_chk.sv
// AXI-stream ramp checker sink: buffers LENGTH beats, sums them, counts ramp mismatches.
// Optional random backpressure is enabled by defining AXIS_SINK_BACKPRESSURE_EN.
module axis_sink_chk #(
  parameter int D_W    = 8,
  parameter int SEED   = 0,
  parameter int LENGTH = 32,
  parameter int SUM_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_axis_valid,
  input  logic [D_W-1:0]            s_axis_data,
  output logic                      s_axis_ready,
  output logic                      done,
  output logic [15:0]               err_count,
  output logic [SUM_W-1:0]          sum,
  input  logic [$clog2(LENGTH):0]   rd_addr,
  output logic [D_W-1:0]            rd_data
);

  localparam int PW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int AW = $clog2(LENGTH) + 1;
  localparam logic [AW-1:0] LEN_A  = AW'(LENGTH);
  localparam logic [PW-1:0] LAST_P = PW'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, RECV, FIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     w_ptr_q, w_ptr_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [15:0]       err_q, err_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [D_W-1:0]    rd_data_q;
  logic [D_W-1:0]    mem [LENGTH];
  logic              accept;
  logic              wr_en;
  logic              recv_ready;
  logic [D_W-1:0]    exp_data;

  assign accept   = s_axis_valid && ready_q;
  assign wr_en    = accept && !rst;
  assign exp_data = D_W'(SEED) + D_W'(w_ptr_q);

`ifdef AXIS_SINK_BACKPRESSURE_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == RECV) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  // Ready is registered from the next LFSR value so it always equals lfsr_q[0] in RECV.
  assign recv_ready = lfsr_d[0];
`else
  assign recv_ready = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    w_ptr_d = w_ptr_q;
    done_d  = done_q;
    err_d   = err_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: state_d = RECV;
      RECV: begin
        if (accept) begin
          sum_d   = sum_q + SUM_W'(s_axis_data);
          w_ptr_d = w_ptr_q + 1'b1;
          if ((s_axis_data != exp_data) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
          end
          if (w_ptr_q == LAST_P) begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      FIN:     state_d = FIN;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RECV) && recv_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_ptr_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      w_ptr_q <= w_ptr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
    end
  end

  // Buffer contents survive reset; a same-address read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_ptr_q] <= s_axis_data;
    if (rst)                  rd_data_q <= '0;
    else if (rd_addr < LEN_A) rd_data_q <= mem[rd_addr[PW-1:0]];
    else                      rd_data_q <= '0;
  end

  assign s_axis_ready = ready_q;
  assign done         = done_q;
  assign err_count    = err_q;
  assign sum          = sum_q;
  assign rd_data      = rd_data_q;

endmodule
